down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 119 +++++++++++
 tb/tb_down_timer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable down-counter with a three-state control FSM (IDLE, RUN, DONE).
// A load is accepted in IDLE. The count then decrements on every enabled edge
// until it reaches zero, and the block gives a single-cycle done pulse on the
// way back to IDLE. An abort during RUN cancels the run without a done pulse.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   load_val    in   [WIDTH] initial count value
//   load_valid  in   requester offers load_val
//   load_ready  out  block can accept a load (IDLE)
//   en          in   decrement enable, sampled while RUN
//   abort       in   cancels a run in progress
//   count       out  [WIDTH] current count, registered
//   busy        out  high while in RUN
//   done        out  single-cycle completion pulse (DONE)
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_dec_s;

    // Ripple-borrow decrement: a chain of 1-bit subtract cells with the
    // borrow into bit 0 tied high, so the result is v - 1 modulo 2^WIDTH.
    // The final borrow-out is deliberately dropped; the FSM never applies
    // this at zero.
    function automatic logic [WIDTH-1:0] dec_ripple(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             b;
        b = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[i] ^ b;
            b    = (~v[i]) & b;
        end
        return r;
    endfunction

    assign count_dec_s = dec_ripple(count_q);

    // Next-state and next-count logic; abort outranks en while running.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    count_d = load_val;
                    state_d = (load_val != CNT_ZERO) ? S_RUN : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    count_d = CNT_ZERO;
                    state_d = S_IDLE;
                end else if (en) begin
                    count_d = count_dec_s;
                    state_d = (count_q == CNT_ONE) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                count_d = CNT_ZERO;
                state_d = S_IDLE;
            end
            default: begin
                count_d = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and count registers; reset clears them without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are decoded purely from registered state and count.
    assign count      = count_q;
    assign load_ready = (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] load_val;
    logic             load_valid;
    logic             load_ready;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    // Reference model: where the timer is in its life and what it holds.
    localparam int PH_IDLE  = 0;
    localparam int PH_COUNT = 1;
    localparam int PH_FIN   = 2;
    int m_phase;
    int m_count;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_val   (load_val),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .en         (en),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"},      {24'd0, count},      m_count);
        chk({tag, ".load_ready"}, {31'd0, load_ready}, (m_phase == PH_IDLE)  ? 32'd1 : 32'd0);
        chk({tag, ".busy"},       {31'd0, busy},       (m_phase == PH_COUNT) ? 32'd1 : 32'd0);
        chk({tag, ".done"},       {31'd0, done},       (m_phase == PH_FIN)   ? 32'd1 : 32'd0);
    endtask

    // Advance the reference by one clock edge given the inputs seen there.
    task automatic model_edge(input logic lv, input int val, input logic e, input logic ab);
        if (m_phase == PH_IDLE) begin
            if (lv) begin
                m_count = val;
                m_phase = (val != 0) ? PH_COUNT : PH_FIN;
            end
        end else if (m_phase == PH_COUNT) begin
            if (ab) begin
                m_count = 0;
                m_phase = PH_IDLE;
            end else if (e) begin
                m_count = m_count - 1;
                if (m_count == 0) m_phase = PH_FIN;
            end
        end else begin
            m_phase = PH_IDLE;
        end
    endtask

    // Drive inputs, take one rising edge, then compare away from the edge.
    task automatic step(input string tag, input logic lv, input int val, input logic e, input logic ab);
        load_valid = lv;
        load_val   = val[WIDTH-1:0];
        en         = e;
        abort      = ab;
        @(posedge clock);
        model_edge(lv, val, e, ab);
        #1;
        chk_all(tag);
    endtask

    int done_seen;

    initial begin
        reset      = 1'b1;
        load_val   = '0;
        load_valid = 1'b0;
        en         = 1'b0;
        abort      = 1'b0;
        m_phase    = PH_IDLE;
        m_count    = 0;

        // Reset with no clock edge yet.
        #2;
        chk_all("reset_async");
        #1;
        reset = 1'b0;

        // Load 3, en held: 3,2,1,0 then back to IDLE.
        step("ld3_acc", 1'b1, 3, 1'b1, 1'b0);
        step("ld3_e1",  1'b0, 0, 1'b1, 1'b0);
        step("ld3_e2",  1'b0, 0, 1'b1, 1'b0);
        step("ld3_e3",  1'b0, 0, 1'b1, 1'b0);
        step("ld3_idle", 1'b0, 0, 1'b1, 1'b0);

        // Load 0: straight to DONE, busy never seen.
        step("ld0_acc",  1'b1, 0, 1'b0, 1'b0);
        step("ld0_idle", 1'b0, 0, 1'b0, 1'b0);

        // Load 2, en pattern 1,0,0,1 with an ignored load of 9 during RUN.
        step("ld2_acc", 1'b1, 2, 1'b0, 1'b0);
        step("ld2_e1",  1'b1, 9, 1'b1, 1'b0);
        step("ld2_e0a", 1'b1, 9, 1'b0, 1'b0);
        step("ld2_e0b", 1'b1, 9, 1'b0, 1'b0);
        step("ld2_e1b", 1'b0, 0, 1'b1, 1'b0);
        step("ld2_idle", 1'b0, 0, 1'b0, 1'b0);

        // Load 8, three enables, then abort together with en.
        step("ld8_acc", 1'b1, 8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("ld8_en", 1'b0, 0, 1'b1, 1'b0);
        chk("ld8_at5", {24'd0, count}, 32'd5);
        step("ld8_abort", 1'b0, 0, 1'b1, 1'b1);
        step("ld8_after", 1'b0, 0, 1'b1, 1'b0);

        // Abort while IDLE does nothing.
        step("idle_abort", 1'b0, 0, 1'b1, 1'b1);

        // Load 255, run down to 100, then reset between edges.
        step("ld255_acc", 1'b1, 255, 1'b1, 1'b0);
        for (int i = 0; i < 155; i++) step("ld255_en", 1'b0, 0, 1'b1, 1'b0);
        chk("ld255_at100", {24'd0, count}, 32'd100);
        reset = 1'b1;
        m_phase = PH_IDLE;
        m_count = 0;
        #1;
        chk_all("midrun_reset");
        @(posedge clock);
        #1;
        chk_all("reset_held");
        reset = 1'b0;
        step("ld1_acc",  1'b1, 1, 1'b1, 1'b0);
        step("ld1_done", 1'b0, 0, 1'b1, 1'b0);
        step("ld1_idle", 1'b0, 0, 1'b1, 1'b0);

        // Random traffic against the reference.
        done_seen = 0;
        for (int i = 0; i < 400; i++) begin
            logic rlv, ren, rab;
            int   rval;
            rlv  = ($urandom_range(0, 3) != 0);
            ren  = ($urandom_range(0, 3) != 0);
            rab  = ($urandom_range(0, 15) == 0);
            rval = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            if (rval > 20) ren = 1'b1;
            step("rand", rlv, rval, ren, rab);
            if (done) done_seen++;
        end
        chk("rand_done_pulses_nonzero", (done_seen > 0) ? 32'd1 : 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
